// File: rtl/hdmi_vid_gen.sv
// Raster timing generator that aligns a frame-delimited pixel stream to the
// active region and feeds the three TMDS encoders with colour, DE and sync.
module hdmi_vid_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        err_clr_i,
  input  logic [23:0] px_i,
  input  logic        px_val_i,
  input  logic        px_sof_i,
  input  logic        px_eol_i,
  output logic        px_rdy_o,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        lock_o,
  output logic        underflow_o,
  output logic        misalign_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, SEEK, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [23:0]   rgb_q;
  logic          de_q, hs_q, vs_q, lock_q, uf_q, ma_q;

  logic active, hs, vs, origin, at_eol, run;
  logic use_px, uf_set, ma_set;

  assign active = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs     = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs     = (v_q >= VS_BEG) && (v_q < VS_END);
  assign origin = (h_q == '0) && (v_q == '0);
  assign at_eol = (h_q == H_EOL);
  assign run    = (state_q != IDLE);

  // Counters sit at the origin whenever the block is (or is about to be) idle.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (state_q == IDLE || !en_i) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = SEEK;
      SEEK:    if (use_px) state_d = LOCKED;
      LOCKED:  if (uf_set || ma_set) state_d = SEEK;
      default: state_d = IDLE;
    endcase
    if (!en_i) state_d = IDLE;
  end

  // SEEK drains non-SOF words and parks an SOF word until the raster origin.
  always_comb begin
    px_rdy_o = 1'b0;
    use_px   = 1'b0;
    uf_set   = 1'b0;
    ma_set   = 1'b0;
    case (state_q)
      SEEK: begin
        px_rdy_o = !(px_val_i && px_sof_i) || origin;
        use_px   = px_val_i && px_sof_i && origin;
      end
      LOCKED: begin
        px_rdy_o = active;
        if (active) begin
          if (!px_val_i)
            uf_set = en_i;
          else if ((px_sof_i != origin) || (px_eol_i != at_eol))
            ma_set = en_i;
          else
            use_px = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q    <= '0;
      v_q    <= '0;
      rgb_q  <= '0;
      de_q   <= 1'b0;
      hs_q   <= !HS_POL;
      vs_q   <= !VS_POL;
      lock_q <= 1'b0;
      uf_q   <= 1'b0;
      ma_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      rgb_q  <= use_px ? px_i : 24'h0;
      de_q   <= run && active;
      hs_q   <= (run && hs) ? HS_POL : !HS_POL;
      vs_q   <= (run && vs) ? VS_POL : !VS_POL;
      lock_q <= (state_d == LOCKED);
      uf_q   <= uf_set | (uf_q & !err_clr_i);
      ma_q   <= ma_set | (ma_q & !err_clr_i);
    end
  end

  assign r_o         = rgb_q[23:16];
  assign g_o         = rgb_q[15:8];
  assign b_o         = rgb_q[7:0];
  assign de_o        = de_q;
  assign hsync_o     = hs_q;
  assign vsync_o     = vs_q;
  assign lock_o      = lock_q;
  assign underflow_o = uf_q;
  assign misalign_o  = ma_q;

endmodule

// File: tb/tb_hdmi_vid_gen.sv
// Directed bench for hdmi_vid_gen on a tiny 8x6 raster (4 active px, 3 active lines).
module tb_hdmi_vid_gen;
  logic        clk_i = 1'b0;
  logic        rst_i, en_i, err_clr_i;
  logic [23:0] px_i;
  logic        px_val_i, px_sof_i, px_eol_i;
  logic        px_rdy_o;
  logic [7:0]  r_o, g_o, b_o;
  logic        de_o, hsync_o, vsync_o, lock_o, underflow_o, misalign_o;

  int checks = 0;
  int failures = 0;
  logic [25:0] q[$];
  logic acc;

  hdmi_vid_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .err_clr_i(err_clr_i),
    .px_i(px_i), .px_val_i(px_val_i), .px_sof_i(px_sof_i), .px_eol_i(px_eol_i),
    .px_rdy_o(px_rdy_o), .r_o(r_o), .g_o(g_o), .b_o(b_o), .de_o(de_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .lock_o(lock_o),
    .underflow_o(underflow_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Source presents the head of its queue; a word leaves only once accepted.
  task automatic drive();
    if (q.size() > 0) begin
      {px_sof_i, px_eol_i, px_i} = q[0];
      px_val_i = 1'b1;
    end else begin
      {px_sof_i, px_eol_i, px_i} = '0;
      px_val_i = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    acc = px_val_i && px_rdy_o;
    @(posedge clk_i);
    #1;
    if (acc) void'(q.pop_front());
    drive();
    #1;
  endtask

  // Words n=first..last of a frame, pixel value 16*v+h; bad_h forces EOL on line 0.
  task automatic push_frame(input int first, input int last, input int bad_h);
    for (int n = first; n <= last; n++) begin
      int v = n / 4;
      int h = n % 4;
      logic s = (n == 0);
      logic e = (h == 3) || (v == 0 && h == bad_h);
      q.push_back({s, e, 24'(16 * v + h)});
    end
  endtask

  initial begin
    logic       exp_de, exp_hs, exp_vs;
    logic [23:0] exp_rgb;

    rst_i = 1'b1; en_i = 1'b0; err_clr_i = 1'b0;
    drive();
    #12;
    chk("reset", {de_o, hsync_o, vsync_o, lock_o, underflow_o, misalign_o, px_rdy_o, r_o, g_o, b_o}, 64'h0);
    @(posedge clk_i); #1; rst_i = 1'b0; #1;

    // Free-running raster, no stream
    en_i = 1'b1;
    tick();
    for (int k = 0; k < 56; k++) begin
      tick();
      exp_de = ((k % 8) < 4) && (((k / 8) % 6) < 3);
      exp_hs = ((k % 8) == 5) || ((k % 8) == 6);
      exp_vs = (((k / 8) % 6) == 4);
      chk($sformatf("timing_k%0d", k), {de_o, hsync_o, vsync_o, lock_o, r_o, g_o, b_o},
          {exp_de, exp_hs, exp_vs, 1'b0, 24'h0});
    end
    en_i = 1'b0;
    tick();

    // Lock onto two back-to-back frames
    push_frame(0, 11, -1);
    push_frame(0, 11, -1);
    drive(); #1;
    chk("idle_rdy", px_rdy_o, 0);
    en_i = 1'b1;
    tick();
    chk("sof_xfer", {px_rdy_o, lock_o}, 2'b10);
    for (int k = 0; k < 96; k++) begin
      tick();
      exp_de  = ((k % 8) < 4) && (((k / 8) % 6) < 3);
      exp_rgb = exp_de ? 24'(16 * ((k / 8) % 6) + (k % 8)) : 24'h0;
      chk($sformatf("lock_k%0d", k), {de_o, lock_o, underflow_o, misalign_o, r_o, g_o, b_o},
          {exp_de, 1'b1, 2'b00, exp_rgb});
    end
    en_i = 1'b0;
    tick();
    chk("lock_disable", {lock_o, underflow_o, misalign_o}, 3'b000);

    // Junk ahead of SOF
    q.push_back({2'b00, 24'hBAD001});
    q.push_back({2'b00, 24'hBAD002});
    q.push_back({2'b01, 24'hBAD003});
    push_frame(0, 11, -1);
    drive();
    en_i = 1'b1;
    tick();
    repeat (3) tick();
    chk("junk_drop", q.size(), 12);
    chk("sof_hold", px_rdy_o, 0);
    repeat (45) tick();
    chk("sof_origin_rdy", px_rdy_o, 1);
    tick();
    chk("drop_lock", {de_o, lock_o, r_o, g_o, b_o}, {2'b11, 24'h0});
    tick();
    chk("drop_px1", {r_o, g_o, b_o}, 24'h000001);
    repeat (30) tick();
    en_i = 1'b0;
    tick();
    chk("drop_flags", {underflow_o, misalign_o}, 2'b00);

    // Underflow at (2,1)
    push_frame(0, 5, -1);
    drive();
    en_i = 1'b1;
    tick();
    repeat (10) tick();
    chk("uf_pre", {lock_o, px_rdy_o, r_o, g_o, b_o}, {2'b11, 24'h000011});
    tick();
    chk("uf_hit", {de_o, underflow_o, lock_o, r_o, g_o, b_o}, {3'b110, 24'h0});
    push_frame(6, 11, -1);
    push_frame(0, 11, -1);
    drive(); #1;
    repeat (37) tick();
    chk("uf_relock_rdy", px_rdy_o, 1);
    tick();
    chk("uf_relock", {de_o, lock_o, underflow_o, r_o, g_o, b_o}, {3'b111, 24'h0});
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("uf_clear", {underflow_o, r_o, g_o, b_o}, {1'b0, 24'h000001});
    repeat (30) tick();
    en_i = 1'b0;
    tick();

    // EOL on (2,0)
    push_frame(0, 11, 2);
    push_frame(0, 11, -1);
    drive();
    en_i = 1'b1;
    tick();
    tick();
    tick();
    chk("ma_pre", {lock_o, r_o, g_o, b_o}, {1'b1, 24'h000001});
    tick();
    chk("ma_hit", {de_o, misalign_o, underflow_o, lock_o, r_o, g_o, b_o}, {4'b1100, 24'h0});
    repeat (45) tick();
    tick();
    chk("ma_relock", {de_o, lock_o, r_o, g_o, b_o}, {2'b11, 24'h0});
    tick();
    chk("ma_px1", {r_o, g_o, b_o}, 24'h000001);
    repeat (8) tick();
    chk("pre_rst", {de_o, misalign_o, r_o, g_o, b_o}, {2'b11, 24'h000011});

    // Asynchronous reset mid line 1
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst", {de_o, hsync_o, vsync_o, lock_o, underflow_o, misalign_o, px_rdy_o, r_o, g_o, b_o}, 64'h0);
    en_i = 1'b0;
    q.delete();
    drive();
    @(posedge clk_i); #1; rst_i = 1'b0; #1;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk($sformatf("idle_k%0d", k), {de_o, hsync_o, vsync_o, lock_o, px_rdy_o}, 5'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
